// File: rtl/chunked_adder_pkg.sv
// Shared types for the chunked adder sequencer: FSM state encoding and slice width.
// Latency: none (declarations only).
// Backpressure: not applicable.
package chunked_adder_pkg;

    localparam int CHUNK = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/chunked_adder_seq_add2_slice.sv
// Two-bit ripple-carry adder slice made of two chained full adders.
// Latency: purely combinational.
// Backpressure: none; the sequencer owns all flow control.
module add2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       ci,
    output logic [1:0] s,
    output logic       co
);

    logic c1;

    assign s[0] = a[0] ^ b[0] ^ ci;
    assign c1   = (a[0] & b[0]) | (a[0] & ci) | (b[0] & ci);
    assign s[1] = a[1] ^ b[1] ^ c1;
    assign co   = (a[1] & b[1]) | (a[1] & c1) | (b[1] & c1);

endmodule

// File: rtl/chunked_adder_seq.sv
// Serial WIDTH-bit adder pushing two bits per clock through one add2_slice; CHUNK_ADDER_OVF_EN adds the ovf port.
// Latency: result valid WIDTH/2 edges after the accept edge (in the WIDTH/2+1-th cycle counting the accept cycle).
// Backpressure: result held in DONE until out_ready; in_ready is high only in IDLE.
module chunked_adder_seq
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef CHUNK_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic [1:0]       slice_s;
    logic             slice_co;

    add2_slice u_slice (
        .a  (a_sh[CHUNK-1:0]),
        .b  (b_sh[CHUNK-1:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // New chunk enters at the top; after NCHUNK steps chunk 0 has reached bit 0.
    assign res_next = (res >> CHUNK) | (WIDTH'(slice_s) << (WIDTH - CHUNK));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    res     <= res_next;
                    carry_q <= slice_co;
                    a_sh    <= a_sh >> CHUNK;
                    b_sh    <= b_sh >> CHUNK;
                    if (cnt == LAST) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = res;
    assign cout      = carry_q;

`ifdef CHUNK_ADDER_OVF_EN
    logic a_msb;
    logic b_msb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit and the operand MSBs.
    assign ovf = out_valid & (carry_q ^ (a_msb ^ b_msb ^ res[WIDTH-1]));
`endif

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Directed self-checking bench for chunked_adder_seq at WIDTH=8 and WIDTH=2.
// Latency figures count rising edges from the accept edge inclusive.
// Backpressure is exercised by stalling out_ready with in_valid pulses.
module tb_chunked_adder_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid8 = 1'b0, out_ready8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       in_ready8, out_valid8, cout8;
    logic [7:0] sum8;

    logic       in_valid2 = 1'b0, out_ready2 = 1'b0, cin2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       in_ready2, out_valid2, cout2;
    logic [1:0] sum2;

`ifdef CHUNK_ADDER_OVF_EN
    logic       ovf8, ovf2;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    chunked_adder_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8),
`ifdef CHUNK_ADDER_OVF_EN
        .cout(cout8), .ovf(ovf8)
`else
        .cout(cout8)
`endif
    );

    chunked_adder_seq #(.WIDTH(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2),
`ifdef CHUNK_ADDER_OVF_EN
        .cout(cout2), .ovf(ovf2)
`else
        .cout(cout2)
`endif
    );

    // Presents one operand pair for a single cycle; returns just after the accept edge.
    task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic c);
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = c; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
    endtask

    task automatic start2(input logic [1:0] av, input logic [1:0] bv, input logic c);
        @(negedge clk);
        a2 = av; b2 = bv; cin2 = c; in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
    endtask

    task automatic wait_valid8(output int edges);
        edges = 1;
        while (!out_valid8 && edges < 30) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic wait_valid2(output int edges);
        edges = 1;
        while (!out_valid2 && edges < 30) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic handoff8;
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        n_cmp++; if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready8); end
        n_cmp++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid8); end
        n_cmp++; if (sum8 !== 8'h00) begin n_err++; $display("FAIL reset_sum: got %h want 00", sum8); end
        n_cmp++; if (cout8 !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b want 0", cout8); end
`ifdef CHUNK_ADDER_OVF_EN
        n_cmp++; if (ovf8 !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf8); end
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int e;
        start8(8'h5A, 8'h3C, 1'b0);
        wait_valid8(e);
        n_cmp++; if (e !== 5) begin n_err++; $display("FAIL basic_latency: got %0d want 5", e); end
        n_cmp++; if (sum8 !== 8'h96) begin n_err++; $display("FAIL basic_sum: got %h want 96", sum8); end
        n_cmp++; if (cout8 !== 1'b0) begin n_err++; $display("FAIL basic_cout: got %b want 0", cout8); end
        handoff8();
        n_cmp++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            n_err++; $display("FAIL basic_after_handoff: got in_ready=%b out_valid=%b want 1/0", in_ready8, out_valid8);
        end
    endtask

    task automatic test_carry;
        int e;
        start8(8'hFF, 8'h01, 1'b0);
        wait_valid8(e);
        n_cmp++; if (sum8 !== 8'h00) begin n_err++; $display("FAIL carry_ff_sum: got %h want 00", sum8); end
        n_cmp++; if (cout8 !== 1'b1) begin n_err++; $display("FAIL carry_ff_cout: got %b want 1", cout8); end
        handoff8();
        start8(8'h00, 8'h00, 1'b1);
        wait_valid8(e);
        n_cmp++; if (sum8 !== 8'h01) begin n_err++; $display("FAIL carry_cin_sum: got %h want 01", sum8); end
        n_cmp++; if (cout8 !== 1'b0) begin n_err++; $display("FAIL carry_cin_cout: got %b want 0", cout8); end
        handoff8();
        start8(8'hA7, 8'hC6, 1'b1);
        wait_valid8(e);
        n_cmp++; if ({cout8, sum8} !== 9'h16E) begin n_err++; $display("FAIL carry_mixed: got %h want 16e", {cout8, sum8}); end
        handoff8();
    endtask

    task automatic test_backpressure;
        int e;
        start8(8'h12, 8'h34, 1'b0);
        wait_valid8(e);
        for (int i = 0; i < 6; i++) begin
            a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
            in_valid8 = (i % 2 == 0);
            @(negedge clk);
            n_cmp++; if (sum8 !== 8'h46 || cout8 !== 1'b0) begin
                n_err++; $display("FAIL bp_hold_%0d: got sum=%h cout=%b want 46/0", i, sum8, cout8);
            end
            n_cmp++; if (in_ready8 !== 1'b0 || out_valid8 !== 1'b1) begin
                n_err++; $display("FAIL bp_flags_%0d: got in_ready=%b out_valid=%b want 0/1", i, in_ready8, out_valid8);
            end
        end
        in_valid8 = 1'b0;
        handoff8();
        n_cmp++; if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL bp_release: got in_ready=%b want 1", in_ready8); end
        @(negedge clk);
        n_cmp++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            n_err++; $display("FAIL bp_no_ghost: got in_ready=%b out_valid=%b want 1/0", in_ready8, out_valid8);
        end
    endtask

    task automatic test_back_to_back;
        int first = -1;
        int second = -1;
        logic [7:0] seen = 8'hxx;
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
        in_valid8 = 1'b1; out_ready8 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid8) seen = sum8;
            if (in_ready8) begin
                if (first < 0) first = i;
                else begin
                    second = i;
                    break;
                end
            end
            @(negedge clk);
        end
        in_valid8 = 1'b0; out_ready8 = 1'b0;
        n_cmp++; if (second - first !== 6) begin
            n_err++; $display("FAIL b2b_spacing: got %0d want 6", second - first);
        end
        n_cmp++; if (seen !== 8'h03) begin n_err++; $display("FAIL b2b_sum: got %h want 03", seen); end
    endtask

    task automatic test_reset_mid;
        int e;
        start8(8'h77, 8'h11, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        n_cmp++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            n_err++; $display("FAIL rstmid_flags: got in_ready=%b out_valid=%b want 1/0", in_ready8, out_valid8);
        end
        n_cmp++; if (sum8 !== 8'h00) begin n_err++; $display("FAIL rstmid_sum: got %h want 00", sum8); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL rstmid_quiet_%0d: got %b want 0", i, out_valid8); end
        end
        start8(8'h10, 8'h20, 1'b0);
        wait_valid8(e);
        n_cmp++; if (sum8 !== 8'h30 || cout8 !== 1'b0) begin
            n_err++; $display("FAIL rstmid_new: got sum=%h cout=%b want 30/0", sum8, cout8);
        end
        handoff8();
    endtask

`ifdef CHUNK_ADDER_OVF_EN
    task automatic test_ovf;
        int e;
        start8(8'h7F, 8'h01, 1'b0);
        wait_valid8(e);
        n_cmp++; if (sum8 !== 8'h80 || ovf8 !== 1'b1) begin
            n_err++; $display("FAIL ovf_pos: got sum=%h ovf=%b want 80/1", sum8, ovf8);
        end
        handoff8();
        n_cmp++; if (ovf8 !== 1'b0) begin n_err++; $display("FAIL ovf_idle: got %b want 0", ovf8); end
        start8(8'hFF, 8'h01, 1'b0);
        wait_valid8(e);
        n_cmp++; if (sum8 !== 8'h00 || cout8 !== 1'b1 || ovf8 !== 1'b0) begin
            n_err++; $display("FAIL ovf_wrap: got sum=%h cout=%b ovf=%b want 00/1/0", sum8, cout8, ovf8);
        end
        handoff8();
    endtask
`endif

    task automatic test_width2;
        int e;
        start2(2'd3, 2'd3, 1'b1);
        wait_valid2(e);
        n_cmp++; if (e !== 2) begin n_err++; $display("FAIL w2_latency: got %0d want 2", e); end
        n_cmp++; if (sum2 !== 2'd3 || cout2 !== 1'b1) begin
            n_err++; $display("FAIL w2_max: got sum=%0d cout=%b want 3/1", sum2, cout2);
        end
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        start2(2'd1, 2'd2, 1'b0);
        wait_valid2(e);
        n_cmp++; if (sum2 !== 2'd3 || cout2 !== 1'b0) begin
            n_err++; $display("FAIL w2_nocarry: got sum=%0d cout=%b want 3/0", sum2, cout2);
        end
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef CHUNK_ADDER_OVF_EN
        test_ovf();
`endif
        test_width2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
